// File: rtl/banked_spfifo.sv
// banked_spfifo: FIFO on NBANK interleaved single-port banks, fixed 2-cycle read latency.
// Optional sticky overflow/underflow ports are enabled with BANKED_SPFIFO_ERR_EN.

module d1spram #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int SRAM  = 1
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en && we) mem[addr] <= wdata;
   end

   // Macro model registers the data; flop model registers the address instead.
   generate
      if (SRAM != 0) begin : g_macro
         always_ff @(posedge clk) begin
            if (en && !we) rdata <= mem[addr];
         end
      end else begin : g_flop
         logic [$clog2(DEPTH)-1:0] addr_q;
         always_ff @(posedge clk) begin
            if (en && !we) addr_q <= addr;
         end
         assign rdata = mem[addr_q];
      end
   endgenerate
endmodule

module banked_spfifo #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 64,
   parameter int NBANK    = 4,
   parameter int SRAM     = 1,
   parameter int AL_FULL  = 2,
   parameter int AL_EMPTY = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic                     ack,
   output logic                     rvalid,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic                     al_full,
   output logic                     al_empty,
   output logic [$clog2(DEPTH):0]   count
`ifdef BANKED_SPFIFO_ERR_EN
   ,
   output logic                     overflow,
   output logic                     underflow
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int BW = $clog2(NBANK);
   localparam int RW = AW - BW;

   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [BW-1:0]    wr_bank, rd_bank, s1_bank;
   logic [RW-1:0]    wr_row, rd_row;
   logic             wen, ren, bypass, wr_do, fwd;
   logic [NBANK-1:0] rd_hit, wr_hit, drain, bank_en, bank_we, pend_valid;
   logic [RW-1:0]    bank_addr  [NBANK];
   logic [WIDTH-1:0] bank_wdata [NBANK];
   logic [WIDTH-1:0] bank_rdata [NBANK];
   logic [RW-1:0]    pend_row   [NBANK];
   logic [WIDTH-1:0] pend_data  [NBANK];
   logic             s1_valid, s1_alt;
   logic [WIDTH-1:0] s1_alt_data;

   assign count   = wr_ptr - rd_ptr;
   assign full    = (count == PW'(DEPTH));
   assign empty   = (count == '0);
   assign wr_bank = wr_ptr[BW-1:0];
   assign wr_row  = wr_ptr[AW-1:BW];
   assign rd_bank = rd_ptr[BW-1:0];
   assign rd_row  = rd_ptr[AW-1:BW];

   assign wen    = push && (!full || pop) && !flush;
   assign ren    = pop && !empty && !flush;
   assign bypass = push && pop && empty && !flush;
   assign wr_do  = wen && !bypass;
   assign ack    = wen;
   assign fwd    = ren && pend_valid[rd_bank] && (pend_row[rd_bank] == rd_row);

   generate
      if (AL_FULL != 0) begin : g_alf
         assign al_full = (count >= PW'(DEPTH - AL_FULL));
      end else begin : g_alf_off
         assign al_full = 1'b0;
      end
      if (AL_EMPTY != 0) begin : g_ale
         assign al_empty = (count <= PW'(AL_EMPTY));
      end else begin : g_ale_off
         assign al_empty = 1'b0;
      end
   endgenerate

   // Per-bank port arbitration: read wins, then a fresh write, then a pending drain.
   always_comb begin
      rd_hit  = '0;
      wr_hit  = '0;
      drain   = '0;
      bank_en = '0;
      bank_we = '0;
      for (int b = 0; b < NBANK; b++) begin
         bank_addr[b]  = rd_row;
         bank_wdata[b] = wdata;
         rd_hit[b] = ren && (rd_bank == BW'(b));
         wr_hit[b] = wr_do && (wr_bank == BW'(b));
         drain[b]  = pend_valid[b] && !rd_hit[b] && !wr_hit[b];
         if (rd_hit[b]) begin
            bank_en[b] = 1'b1;
         end else if (wr_hit[b]) begin
            bank_en[b]   = 1'b1;
            bank_we[b]   = 1'b1;
            bank_addr[b] = wr_row;
         end else if (drain[b]) begin
            bank_en[b]    = 1'b1;
            bank_we[b]    = 1'b1;
            bank_addr[b]  = pend_row[b];
            bank_wdata[b] = pend_data[b];
         end
      end
   end

   generate
      for (genvar g = 0; g < NBANK; g++) begin : g_bank
         d1spram #(.WIDTH(WIDTH), .DEPTH(DEPTH / NBANK), .SRAM(SRAM)) u_ram (
            .clk   (clk),
            .en    (bank_en[g]),
            .we    (bank_we[g]),
            .addr  (bank_addr[g]),
            .wdata (bank_wdata[g]),
            .rdata (bank_rdata[g])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_do) wr_ptr <= wr_ptr + 1'b1;
         if (ren)   rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // A write that collides with a read on its bank is parked until the bank is idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_valid <= '0;
         for (int b = 0; b < NBANK; b++) begin
            pend_row[b]  <= '0;
            pend_data[b] <= '0;
         end
      end else if (flush) begin
         pend_valid <= '0;
      end else begin
         for (int b = 0; b < NBANK; b++) begin
            if (rd_hit[b] && wr_hit[b]) begin
               pend_valid[b] <= 1'b1;
               pend_row[b]   <= wr_row;
               pend_data[b]  <= wdata;
            end else if (drain[b]) begin
               pend_valid[b] <= 1'b0;
            end
         end
      end
   end

   // Stage 1 tracks the bank access; stage 2 picks bank data or the bypass/forwarded word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid    <= 1'b0;
         s1_alt      <= 1'b0;
         s1_alt_data <= '0;
         s1_bank     <= '0;
         rvalid      <= 1'b0;
         rdata       <= '0;
      end else if (flush) begin
         s1_valid <= 1'b0;
         rvalid   <= 1'b0;
      end else begin
         s1_valid    <= ren || bypass;
         s1_alt      <= bypass || fwd;
         s1_alt_data <= bypass ? wdata : pend_data[rd_bank];
         s1_bank     <= rd_bank;
         rvalid      <= s1_valid;
         if (s1_valid) rdata <= s1_alt ? s1_alt_data : bank_rdata[s1_bank];
      end
   end

`ifdef BANKED_SPFIFO_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push && full && !pop)  overflow  <= 1'b1;
         if (pop && empty && !push) underflow <= 1'b1;
      end
   end
`endif

   pend_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(|(rd_hit & wr_hit & pend_valid)));
endmodule

// File: tb/tb_banked_spfifo.sv
// tb_banked_spfifo: directed and random traffic checked against a queue-based reference.
// Build with BANKED_SPFIFO_ERR_EN to also check the sticky error ports.

module tb_banked_spfifo;
   localparam int WIDTH = 16;
   localparam int DEPTH = 64;

   logic             clk = 1'b0;
   logic             rst_n, flush, push, pop;
   logic [WIDTH-1:0] wdata;
   logic             ack, rvalid, full, empty, al_full, al_empty;
   logic [WIDTH-1:0] rdata;
   logic [6:0]       count;
`ifdef BANKED_SPFIFO_ERR_EN
   logic             overflow, underflow;
   bit               m_ovf, m_unf;
`endif

   logic [WIDTH-1:0] mq [$];
   bit               p1v, p2v, exp_ack;
   logic [WIDTH-1:0] p1d, p2d, last_rdata;
   int               vectors = 0;
   int               miscompares = 0;

   banked_spfifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NBANK(4), .SRAM(1),
                   .AL_FULL(2), .AL_EMPTY(2)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .wdata(wdata),
      .pop(pop), .ack(ack), .rvalid(rvalid), .rdata(rdata), .full(full),
      .empty(empty), .al_full(al_full), .al_empty(al_empty), .count(count)
`ifdef BANKED_SPFIFO_ERR_EN
      , .overflow(overflow), .underflow(underflow)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      int sz;
      sz = mq.size();
      exp_ack = push && !flush && (sz < DEPTH || pop);
      if (p2v) last_rdata = p2d;
      checkVal({tag, " ack"},      32'(ack),      32'(exp_ack));
      checkVal({tag, " count"},    32'(count),    32'(sz));
      checkVal({tag, " empty"},    32'(empty),    32'(sz == 0));
      checkVal({tag, " full"},     32'(full),     32'(sz == DEPTH));
      checkVal({tag, " al_full"},  32'(al_full),  32'(sz >= DEPTH - 2));
      checkVal({tag, " al_empty"}, 32'(al_empty), 32'(sz <= 2));
      checkVal({tag, " rvalid"},   32'(rvalid),   32'(p2v));
      checkVal({tag, " rdata"},    32'(rdata),    32'(last_rdata));
`ifdef BANKED_SPFIFO_ERR_EN
      checkVal({tag, " overflow"},  32'(overflow),  32'(m_ovf));
      checkVal({tag, " underflow"}, 32'(underflow), 32'(m_unf));
`endif
   endtask

   task automatic resetModel();
      mq.delete();
      p1v = 0; p2v = 0;
      p1d = '0; p2d = '0;
      last_rdata = '0;
`ifdef BANKED_SPFIFO_ERR_EN
      m_ovf = 0; m_unf = 0;
`endif
   endtask

   // One clock: drive, check state plus combinational ack, then advance the model.
   task automatic applyStimulus(input string tag, input bit p, input bit q,
                                input logic [WIDTH-1:0] d, input bit f);
      bit               cur_v;
      logic [WIDTH-1:0] cur_d;
      @(negedge clk);
      push = p; pop = q; wdata = d; flush = f;
      #1;
      checkOutput(tag);
`ifdef BANKED_SPFIFO_ERR_EN
      if (f) begin
         m_ovf = 0; m_unf = 0;
      end else begin
         if (p && mq.size() == DEPTH && !q) m_ovf = 1;
         if (q && mq.size() == 0 && !p)     m_unf = 1;
      end
`endif
      cur_v = 0;
      cur_d = '0;
      if (f) begin
         mq.delete();
      end else begin
         if (exp_ack) mq.push_back(d);
         if (q && mq.size() > 0) begin
            cur_v = 1;
            cur_d = mq.pop_front();
         end
      end
      p2v = p1v; p2d = p1d;
      p1v = cur_v; p1d = cur_d;
      if (f) begin
         p1v = 0; p2v = 0;
      end
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; wdata = '0;
      resetModel();
      #1;
      checkOutput("reset");
      #6 rst_n = 1'b1;

      for (int i = 0; i < 64; i++) applyStimulus("fill", 1, 0, WIDTH'(i), 0);
      applyStimulus("full_hold", 0, 0, '0, 0);
      for (int i = 0; i < 64; i++) applyStimulus("drain", 0, 1, '0, 0);
      for (int i = 0; i < 3; i++)  applyStimulus("drain_tail", 0, 0, '0, 0);

      for (int i = 0; i < 10; i++)  applyStimulus("prefill", 1, 0, WIDTH'(16'h100 + i), 0);
      for (int i = 0; i < 200; i++) applyStimulus("stream", 1, 1, WIDTH'(16'h200 + i), 0);
      for (int i = 0; i < 13; i++)  applyStimulus("stream_drain", 0, 1, '0, 0);

      applyStimulus("bypass", 1, 1, 16'hA5A5, 0);
      for (int i = 0; i < 3; i++) applyStimulus("bypass_tail", 0, 0, '0, 0);

      for (int i = 0; i < 64; i++) applyStimulus("fill2", 1, 0, WIDTH'(16'h3000 + i), 0);
      applyStimulus("full_pushpop", 1, 1, 16'h1234, 0);
      applyStimulus("full_push", 1, 0, 16'hDEAD, 0);
      applyStimulus("full_idle", 0, 0, '0, 0);
      for (int i = 0; i < 64; i++) applyStimulus("drain2", 0, 1, '0, 0);
      applyStimulus("empty_pop", 0, 1, '0, 0);
      for (int i = 0; i < 3; i++) applyStimulus("drain2_tail", 0, 0, '0, 0);

      for (int i = 0; i < 7; i++) applyStimulus("pre_flush", 1, 0, WIDTH'(16'h40 + i), 0);
      applyStimulus("inflight", 0, 1, '0, 0);
      applyStimulus("inflight", 0, 1, '0, 0);
      applyStimulus("flush", 1, 1, 16'hBEEF, 1);
      for (int i = 0; i < 3; i++) applyStimulus("post_flush", 0, 0, '0, 0);
      applyStimulus("post_push", 1, 0, 16'h0001, 0);
      applyStimulus("post_pop", 0, 1, '0, 0);
      for (int i = 0; i < 3; i++) applyStimulus("post_tail", 0, 0, '0, 0);

      for (int i = 0; i < 10000; i++) begin
         if (i == 5000) begin
            @(negedge clk);
            push = 1'b0; pop = 1'b0; flush = 1'b0; wdata = '0;
            #2 rst_n = 1'b0;
            #1;
            resetModel();
            checkOutput("async_reset");
            #1 rst_n = 1'b1;
         end
         applyStimulus("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       WIDTH'($urandom), ($urandom_range(0, 127) == 0));
      end
      for (int i = 0; i < 3; i++) applyStimulus("final", 0, 0, '0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
